// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter: round-robin arbiter for two requesters sharing one dcache request port
package dcache_pkg;
  typedef struct packed {
    logic        valid;
    logic [1:0]  mem_op;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] write_content;
    logic [31:0] pc;
  } DCACHE_REQUEST;
endpackage

module dcache_req_arbiter
  import dcache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  DCACHE_REQUEST    req0_request,
  output logic             req0_stall,
  input  DCACHE_REQUEST    req1_request,
  output logic             req1_stall,
  output DCACHE_REQUEST    cache_request,
  input  logic             cache_stall,
  output logic             grant_id,
  output logic [CNT_W-1:0] conflict_count
);
  DCACHE_REQUEST out_q, out_d, pick;
  logic grant_q, rr_q, load_en, sel, acc, both;
  logic [CNT_W-1:0] cnt_q;

  // Selection: a lone valid requester wins outright, otherwise the round-robin pointer decides
  always_comb begin
    load_en    = !out_q.valid || !cache_stall;
    both       = req0_request.valid && req1_request.valid;
    sel        = (req0_request.valid ^ req1_request.valid) ? req1_request.valid : rr_q;
    pick       = sel ? req1_request : req0_request;
    acc        = load_en && pick.valid;
    out_d      = acc ? pick : '0;
    req0_stall = !(load_en && !sel);
    req1_stall = !(load_en && sel);
  end

  // Output stage, grant, pointer and saturating contention counter; all frozen while the cache stalls a valid packet
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (load_en) out_q <= out_d;
      if (acc) begin
        grant_q <= sel;
        rr_q    <= ~sel;
      end
      if (load_en && both && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cache_request  = out_q;
  assign grant_id       = grant_q;
  assign conflict_count = cnt_q;
endmodule

// File: tb/tb_dcache_req_arbiter.sv
// tb_dcache_req_arbiter: directed self-checking bench for dcache_req_arbiter
module tb_dcache_req_arbiter;
  import dcache_pkg::*;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cache_stall = 1'b0;
  DCACHE_REQUEST r0 = '0, r1 = '0;
  logic          s0, s1, s0b, s1b, g, gb;
  DCACHE_REQUEST cr, crb;
  logic [15:0]   cnt;
  logic [1:0]    cnt2;
  int            tests = 0, fails = 0;

  always #5 clock = ~clock;

  dcache_req_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req0_request(r0), .req0_stall(s0),
    .req1_request(r1), .req1_stall(s1),
    .cache_request(cr), .cache_stall(cache_stall),
    .grant_id(g), .conflict_count(cnt)
  );

  dcache_req_arbiter #(.CNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .req0_request(r0), .req0_stall(s0b),
    .req1_request(r1), .req1_stall(s1b),
    .cache_request(crb), .cache_stall(cache_stall),
    .grant_id(gb), .conflict_count(cnt2)
  );

  function automatic DCACHE_REQUEST mk(input logic v, input logic [31:0] a,
                                       input logic [1:0] op = 2'd0, input logic [31:0] wc = 32'h0,
                                       input logic [31:0] pc = 32'h0);
    DCACHE_REQUEST p;
    p.valid = v; p.mem_op = op; p.addr = a; p.size = 2'd2; p.write_content = wc; p.pc = pc;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clock) reset_n = 1'b0;
    @(negedge clock) reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a0, a1;
    logic [31:0] exp_a[6];
    logic        exp_g[6];
    logic [1:0]  exp_c2[5];
    DCACHE_REQUEST st;
    exp_a  = '{32'h10, 32'h20, 32'h14, 32'h24, 32'h18, 32'h28};
    exp_g  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_c2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // reset state
    #1;
    chk("rst_valid", cr.valid, 0);
    chk("rst_payload", cr, 0);
    chk("rst_grant", g, 0);
    chk("rst_count", cnt, 0);
    chk("rst_stall0", s0, 0);
    chk("rst_stall1", s1, 1);
    @(negedge clock) reset_n = 1'b1;

    // single request from requester 0
    r0 = mk(1'b1, 32'h100);
    #1 chk("t1_stall0", s0, 0);
    tick();
    r0 = '0;
    chk("t1_valid", cr.valid, 1);
    chk("t1_addr", cr.addr, 32'h100);
    chk("t1_grant", g, 0);
    tick();
    chk("t1_empty", cr.valid, 0);

    // continuous ties alternate 0,1,0,1
    pulse_reset();
    a0 = 32'h10; a1 = 32'h20;
    r0 = mk(1'b1, a0); r1 = mk(1'b1, a1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t2_grant%0d", i), g, exp_g[i]);
      chk($sformatf("t2_addr%0d", i), cr.addr, exp_a[i]);
      if (exp_g[i]) a1 += 4; else a0 += 4;
      r0 = mk(1'b1, a0); r1 = mk(1'b1, a1);
    end
    chk("t2_count", cnt, 6);

    // cache stall holds the output and freezes arbitration state
    r0 = '0; r1 = mk(1'b1, 32'h40);
    tick();
    chk("t3_addr_load", cr.addr, 32'h40);
    chk("t3_grant_load", g, 1);
    cache_stall = 1'b1;
    r0 = mk(1'b1, 32'h80); r1 = mk(1'b1, 32'h44);
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("t3_stall0_%0d", i), s0, 1);
      chk($sformatf("t3_stall1_%0d", i), s1, 1);
      tick();
      chk($sformatf("t3_hold%0d", i), cr.addr, 32'h40);
      chk($sformatf("t3_cnt%0d", i), cnt, 6);
    end
    cache_stall = 1'b0;
    #1 chk("t3_release_stall0", s0, 0);
    tick();
    r0 = '0; r1 = '0;
    chk("t3_addr_after", cr.addr, 32'h80);
    chk("t3_grant_after", g, 0);
    chk("t3_cnt_after", cnt, 7);
    tick();
    chk("t3_drain", cr.valid, 0);

    // load into an empty output stage while the cache stalls
    cache_stall = 1'b1;
    st = mk(1'b1, 32'h200, 2'd1, 32'hDEADBEEF, 32'h1234);
    r0 = st;
    #1 chk("t4_stall0", s0, 0);
    tick();
    r0 = '0;
    chk("t4_pkt", cr, st);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t4_hold%0d", i), cr, st);
    end
    chk("t4_wdata", cr.write_content, 32'hDEADBEEF);
    cache_stall = 1'b0;
    tick();
    chk("t4_consumed", cr.valid, 0);

    // saturation of a 2-bit counter
    pulse_reset();
    r0 = mk(1'b1, 32'h300); r1 = mk(1'b1, 32'h400);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t5_cnt2_%0d", i), cnt2, exp_c2[i]);
      chk($sformatf("t5_cnt16_%0d", i), cnt, i + 1);
    end

    // asynchronous reset mid-stream
    chk("t6_valid_before", cr.valid, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_async_valid", cr.valid, 0);
    chk("t6_async_valid2", crb.valid, 0);
    chk("t6_async_cnt", cnt, 0);
    @(negedge clock) reset_n = 1'b1;
    tick();
    chk("t6_first_grant", g, 0);
    chk("t6_first_addr", cr.addr, 32'h300);
    r0 = '0; r1 = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dcache_req_arbiter.md
# dcache_req_arbiter

Two-requester arbiter sharing the single data-cache request port. It sits between two request sources, such as the load unit and the store unit, or two trace drivers, and the dcache. It accepts `DCACHE_REQUEST` packets from each source under a valid/stall handshake. It forwards one packet per cycle through a registered output stage, chosen round-robin, and honours the cache's `stall` backpressure.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating contention counter.

Ports:
- `clock`  in  1  single clock for all state, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_request`  in  `DCACHE_REQUEST`  requester 0 packet; `.valid` qualifies it.
- `req0_stall`  out  1  high means requester 0's packet is not accepted this cycle and must be held.
- `req1_request`  in  `DCACHE_REQUEST`  requester 1 packet.
- `req1_stall`  out  1  high means requester 1's packet is not accepted this cycle.
- `cache_request`  out  `DCACHE_REQUEST`  registered packet presented to the dcache.
- `cache_stall`  in  1  dcache backpressure; high means `cache_request` is not consumed.
- `grant_id`  out  1  ID of the requester whose packet is in `cache_request`.
- `conflict_count`  out  `CNT_W`  number of cycles in which both requesters were valid and one was refused by arbitration.

## Operation
- Output register `out_q` holds a `DCACHE_REQUEST`, and `cache_request = out_q`.
  - The dcache consumes `out_q` at a rising edge where `out_q.valid && !cache_stall`.
- `load_en = !out_q.valid || !cache_stall`: the output register can take a new packet.
- Selection `sel`, combinational:
  - exactly one valid requester: `sel` is that requester.
  - both valid: `sel = rr_ptr`.
  - none valid: `sel = rr_ptr`.
- Accept condition: `acceptN = load_en && (sel==N) && reqN_request.valid`.
- Stall outputs: `reqN_stall = !(load_en && sel==N)`.
  - A non-valid requester may therefore see its stall low; this is harmless.
- At a rising edge with `load_en`:
  - `out_q` takes the selected packet if it is valid.
  - Otherwise `out_q.valid` becomes 0 and the payload is don't-care.
  - `grant_id` takes `sel` on an accept.
- At a rising edge with `!load_en`: `out_q` and `grant_id` hold.
- Round-robin pointer `rr_ptr` updates only on an accept: `rr_ptr` becomes `~sel`, so the other requester wins the next tie.
- `conflict_count` increments by 1 at an edge where `load_en` is high and both requests are valid.
  - It saturates at `2^CNT_W-1` and never wraps.
- The packet payload is passed through unmodified: `mem_op`, `addr`, `size`, `write_content` and `pc` are bit-exact.
- No reordering within one requester. Packets from requester N reach the cache in acceptance order.

## Timing
- Reset (`reset_n` low, asynchronous, immediate):
  - `out_q.valid=0`, with the `out_q` payload cleared to 0.
  - `grant_id=0`, `rr_ptr=0` (requester 0 wins the first tie), `conflict_count=0`.
- During reset and in the first cycle after it, `load_en=1`. As a result `req0_stall=0` and `req1_stall=1`.
- Latency: a packet accepted at edge T appears on `cache_request` immediately after T, giving 1 cycle of latency.
- Throughput: 1 packet per cycle while `cache_stall` is low. Ties alternate 0,1,0,1.
- `cache_stall` high with `out_q.valid=1`:
  - `out_q` holds and both stalls are high.
  - `rr_ptr` and `conflict_count` are frozen.
- `cache_stall` high with `out_q.valid=0`: the load is still allowed, and the packet then waits in `out_q`.
- `cache_stall` falling at edge T: the packet in `out_q` is consumed at T, and a new packet may be accepted at the same edge T (simultaneous consume and load).
- Requesters must hold `reqN_request` stable while `reqN_stall` is high. The arbiter samples the packet only on accept.
- Reset asserted mid-operation: the in-flight `out_q` packet is discarded. Requesters reissue after reset.
- All outputs except `reqN_stall` are registered. `reqN_stall` is combinational from `cache_stall`, `out_q.valid`, the requester valids and `rr_ptr`.

## Test plan
- Reset, then requester 0 only sends `addr` 0x100 for 1 cycle with `cache_stall=0`:
  - `req0_stall=0`.
  - The next cycle shows `cache_request.valid=1`, `addr=0x100`, `grant_id=0`.
  - The cycle after shows `valid=0`.
- Both requesters valid continuously, holding their packets while stalled (requester 0 streams `addr` 0x10,0x14,…; requester 1 streams 0x20,0x24,…) for 6 cycles, with no cache stall:
  - `grant_id` sequence is 0,1,0,1,0,1.
  - `cache_request.addr` sequence is 0x10,0x20,0x14,0x24,0x18,0x28.
  - `conflict_count=6`.
- Requester 1 sends `addr` 0x40, then `cache_stall=1` for 9 cycles while requester 0 holds `addr` 0x80:
  - `cache_request.addr` stays 0x40 for the whole stall.
  - `req0_stall=1` and `req1_stall=1` throughout.
  - `conflict_count` is unchanged.
  - On the edge where the stall drops, 0x40 is consumed and 0x80 loads. Next cycle shows `addr=0x80`, `grant_id=0`.
- `cache_stall=1` with `out_q` empty, requester 0 sends a store with `write_content=0xDEADBEEF`:
  - The packet is accepted (`req0_stall=0`) and appears on `cache_request`.
  - It holds until `cache_stall` drops.
  - The store payload matches bit-exact.
- Set `CNT_W=2`, then apply 5 tie cycles: `conflict_count` reads 1,2,3,3,3 (saturation, no wrap).
- Drop `reset_n` mid-stream while `out_q.valid=1`:
  - `cache_request.valid` goes to 0 immediately, without waiting for a clock edge.
  - After release, the first tie is granted to requester 0.
